// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic PORT_CPU      = 1'b0;
  localparam logic PORT_DBG      = 1'b1;
  localparam int   MEM_WORDS_DEF = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a single requester always wins, a tie goes to
// the port that did not win last time.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic lastGrant,
  output logic grantValid,
  output logic grantId
);

  always_comb begin
    grantValid = req0 | req1;
    grantId    = PORT_CPU;
    if (req0 && req1) grantId = ~lastGrant;
    else if (req1)    grantId = PORT_DBG;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported asynchronous data memory between the CPU MEM stage
// (port 0) and the debug/DMA loader (port 1), one req/ack transaction at a time.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MEM_WORDS     = MEM_WORDS_DEF,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memData,
  output logic              memReadFlag,
  output logic              memWriteFlag,
  input  logic [DATA_W-1:0] memRdata
);

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t            state, stateNext;
  logic [3:0]        cnt;
  logic              lastGrant, winId, latWe, errFlag;
  logic [DATA_W-1:0] latAddr, latWdata;

  logic              grantValid, grantId;
  logic              selWe, inRange;
  logic [DATA_W-1:0] selAddr, selWdata;

  rr_arbiter2 uArb (
    .req0       (req0),
    .req1       (req1),
    .lastGrant  (lastGrant),
    .grantValid (grantValid),
    .grantId    (grantId)
  );

  assign selWe    = (grantId == PORT_DBG) ? we1    : we0;
  assign selAddr  = (grantId == PORT_DBG) ? addr1  : addr0;
  assign selWdata = (grantId == PORT_DBG) ? wdata1 : wdata0;
  assign inRange  = selAddr < DATA_W'(MEM_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantValid) stateNext = inRange ? ACCESS : DONE;
      ACCESS:  if (cnt == '0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Everything the memory and requesters see is decoded from state, so an
  // async reset drops strobes and acks immediately.
  always_comb begin
    memAddr      = '0;
    memData      = '0;
    memReadFlag  = 1'b0;
    memWriteFlag = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    err0         = 1'b0;
    err1         = 1'b0;
    case (state)
      ACCESS: begin
        memAddr      = latAddr;
        memData      = latWdata;
        memWriteFlag = latWe;
        memReadFlag  = ~latWe;
      end
      DONE: begin
        ack0 = (winId == PORT_CPU);
        ack1 = (winId == PORT_DBG);
        err0 = (winId == PORT_CPU) & errFlag;
        err1 = (winId == PORT_DBG) & errFlag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lastGrant <= PORT_DBG;
      winId     <= PORT_CPU;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      errFlag   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: if (grantValid) begin
          winId     <= grantId;
          lastGrant <= grantId;
          latWe     <= selWe;
          latAddr   <= selAddr;
          latWdata  <= selWdata;
          errFlag   <= ~inRange;
          cnt       <= CNT_INIT;
          // Out-of-range reads return zero in the ack cycle.
          if (!inRange) begin
            if (grantId == PORT_DBG) rdata1 <= '0;
            else                     rdata0 <= '0;
          end
        end
        ACCESS: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (cnt == '0 && !latWe) begin
            if (winId == PORT_DBG) rdata1 <= memRdata;
            else                   rdata0 <= memRdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (1 and 4 access cycles) checked every
// cycle against a transaction-schedule model, plus directed literal checks.
module tb_dmem_arbiter;

  typedef struct {
    bit          rd, wr, a0, a1, e0, e1;
    logic [31:0] addr, data, r0, r1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req0 = '0, req1 = '0, we0 = '0, we1 = '0;
  logic [31:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
  logic [1:0]  ack0D, ack1D, err0D, err1D, rdF, wrF;
  logic [31:0] rdata0D [2], rdata1D [2], memAddrD [2], memDataD [2], memRdataD [2];

  logic [31:0] mem [2][32];
  logic [31:0] modelMem [2][32];
  exp_t        expQ [2][$];
  exp_t        cur [2];
  logic [31:0] held0 [2], held1 [2];
  bit          lastG [2];
  bit          mInit = 0;

  int tests = 0;
  int fails = 0;
  int wrCnt [2];

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 2; k++) begin
      addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0; wrCnt[k] = 0;
    end
  end

  dmem_arbiter #(.DATA_W(32), .MEM_WORDS(32), .ACCESS_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .ack0(ack0D[0]), .rdata0(rdata0D[0]), .err0(err0D[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .ack1(ack1D[0]), .rdata1(rdata1D[0]), .err1(err1D[0]),
    .memAddr(memAddrD[0]), .memData(memDataD[0]),
    .memReadFlag(rdF[0]), .memWriteFlag(wrF[0]), .memRdata(memRdataD[0])
  );

  dmem_arbiter #(.DATA_W(32), .MEM_WORDS(32), .ACCESS_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .ack0(ack0D[1]), .rdata0(rdata0D[1]), .err0(err0D[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .ack1(ack1D[1]), .rdata1(rdata1D[1]), .err1(err1D[1]),
    .memAddr(memAddrD[1]), .memData(memDataD[1]),
    .memReadFlag(rdF[1]), .memWriteFlag(wrF[1]), .memRdata(memRdataD[1])
  );

  function automatic logic [31:0] initVal(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
  endfunction

  function automatic int acOf(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Asynchronous memory: combinational read, write committed on the clock edge.
  assign memRdataD[0] = mem[0][memAddrD[0][4:0]];
  assign memRdataD[1] = mem[1][memAddrD[1][4:0]];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) mem[k][i] = initVal(i);
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        if (wrF[k]) mem[k][memAddrD[k][4:0]] = memDataD[k];
    end
  end

  function automatic exp_t mkIdle(input int k);
    exp_t e;
    e.rd = 0; e.wr = 0; e.a0 = 0; e.a1 = 0; e.e0 = 0; e.e1 = 0;
    e.addr = '0; e.data = '0; e.r0 = held0[k]; e.r1 = held1[k];
    return e;
  endfunction

  // Model: when idle and someone requests, lay out the whole transaction as
  // a list of per-cycle expected outputs (strobe cycles, then the ack cycle).
  task automatic schedule(input int k);
    bit          p, we;
    logic [31:0] a, d;
    exp_t        e;
    p  = (req0[k] && req1[k]) ? !lastG[k] : req1[k];
    lastG[k] = p;
    we = p ? we1[k] : we0[k];
    a  = p ? addr1[k] : addr0[k];
    d  = p ? wdata1[k] : wdata0[k];
    if (a >= 32) begin
      if (p) held1[k] = '0; else held0[k] = '0;
      e = mkIdle(k); e.a0 = !p; e.a1 = p; e.e0 = !p; e.e1 = p;
      expQ[k].push_back(e);
    end else begin
      for (int i = 0; i < acOf(k); i++) begin
        e = mkIdle(k); e.rd = !we; e.wr = we; e.addr = a; e.data = d;
        expQ[k].push_back(e);
      end
      if (we) modelMem[k][a[4:0]] = d;
      else if (p) held1[k] = modelMem[k][a[4:0]];
      else held0[k] = modelMem[k][a[4:0]];
      e = mkIdle(k); e.a0 = !p; e.a1 = p;
      expQ[k].push_back(e);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (!mInit) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) modelMem[k][i] = initVal(i);
      mInit = 1;
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        expQ[k].delete();
        held0[k] = '0; held1[k] = '0; lastG[k] = 1;
        cur[k] = mkIdle(k);
      end else begin
        if (!cur[k].rd && !cur[k].wr && !cur[k].a0 && !cur[k].a1 &&
            expQ[k].size() == 0 && (req0[k] || req1[k]))
          schedule(k);
        if (expQ[k].size() != 0) cur[k] = expQ[k].pop_front();
        else cur[k] = mkIdle(k);
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic chkB(input string nm, input int k, input logic act, input logic exp);
    chk(nm, k, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic compareAll();
    for (int k = 0; k < 2; k++) begin
      chkB("memReadFlag", k, rdF[k], cur[k].rd);
      chkB("memWriteFlag", k, wrF[k], cur[k].wr);
      chk("memAddr", k, memAddrD[k], cur[k].addr);
      chk("memData", k, memDataD[k], cur[k].data);
      chkB("ack0", k, ack0D[k], cur[k].a0);
      chkB("ack1", k, ack1D[k], cur[k].a1);
      chkB("err0", k, err0D[k], cur[k].e0);
      chkB("err1", k, err1D[k], cur[k].e1);
      chk("rdata0", k, rdata0D[k], cur[k].r0);
      chk("rdata1", k, rdata1D[k], cur[k].r1);
      chkB("strobeOverlap", k, rdF[k] & wrF[k], 1'b0);
      chkB("ackOverlap", k, ack0D[k] & ack1D[k], 1'b0);
      if (wrF[k]) wrCnt[k]++;
    end
  endtask

  task automatic setReq(input int k, input bit p, input bit on, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1[k] = on; we1[k] = we; addr1[k] = a; wdata1[k] = d; end
    else   begin req0[k] = on; we0[k] = we; addr0[k] = a; wdata0[k] = d; end
  endtask

  task automatic doReq(input int k, input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output bit er,
                       output int lat);
    @(negedge clk);
    setReq(k, p, 1, we, a, d);
    lat = 0; rd = '0; er = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((p ? ack1D[k] : ack0D[k]) === 1'b1) begin
        lat = c;
        rd  = p ? rdata1D[k] : rdata0D[k];
        er  = p ? err1D[k] : err0D[k];
        break;
      end
    end
    setReq(k, p, 0, 0, '0, '0);
  endtask

  task automatic contend(input int k);
    int order [$];
    @(negedge clk);
    setReq(k, 0, 1, 0, 32'd3, '0);
    setReq(k, 1, 1, 0, 32'd4, '0);
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ack0D[k]) order.push_back(0);
      if (ack1D[k]) order.push_back(1);
    end
    setReq(k, 0, 0, 0, '0, '0);
    setReq(k, 1, 0, 0, '0, '0);
    chk("grantCount", k, 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk("grantOrder", k, 32'(order[i]), 32'(i % 2));
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    int          lat, w0;

    fork
      forever begin
        @(negedge clk);
        compareAll();
      end
    join_none

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chkB("resetAck0", 0, ack0D[0], 1'b0);
    chk("resetRdata0", 1, rdata0D[1], 32'd0);
    rst = 1'b0;

    // Port-0 read of mem[5] with single-cycle access, cycle by cycle.
    @(negedge clk);
    setReq(0, 0, 1, 0, 32'd5, '0);
    @(negedge clk);
    chkB("t2ReadFlag", 0, rdF[0], 1'b1);
    chk("t2Addr", 0, memAddrD[0], 32'd5);
    chkB("t2NoAckYet", 0, ack0D[0], 1'b0);
    @(negedge clk);
    chkB("t2Ack", 0, ack0D[0], 1'b1);
    chk("t2Rdata", 0, rdata0D[0], 32'hDEAD_BEEF);
    chkB("t2Err", 0, err0D[0], 1'b0);
    setReq(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    chkB("t2AckOnePulse", 0, ack0D[0], 1'b0);

    // Port-1 write to the last word, then port-0 read back, on both instances.
    for (int k = 0; k < 2; k++) begin
      w0 = wrCnt[k];
      doReq(k, 1, 1, 32'd31, 32'h1234_5678, rd, er, lat);
      chk("t3WrLatency", k, 32'(lat), 32'(acOf(k) + 1));
      chk("t3WrStrobeCycles", k, 32'(wrCnt[k] - w0), 32'(acOf(k)));
      doReq(k, 0, 0, 32'd31, '0, rd, er, lat);
      chk("t3RdLatency", k, 32'(lat), 32'(acOf(k) + 1));
      chk("t3Readback", k, rd, 32'h1234_5678);
    end

    // Out-of-range: port 1 first loads a value, then addr 32 must zero it.
    doReq(0, 1, 0, 32'd5, '0, rd, er, lat);
    chk("t5PreRdata1", 0, rd, 32'hDEAD_BEEF);
    @(negedge clk);
    setReq(0, 1, 1, 0, 32'd32, '0);
    @(negedge clk);
    chkB("t5Ack1", 0, ack1D[0], 1'b1);
    chkB("t5Err1", 0, err1D[0], 1'b1);
    chk("t5Rdata1", 0, rdata1D[0], 32'd0);
    chkB("t5NoRead", 0, rdF[0], 1'b0);
    setReq(0, 1, 0, 0, '0, '0);
    doReq(1, 1, 1, 32'hFFFF_FFFF, 32'h0BAD_0BAD, rd, er, lat);
    chk("t5LatencyAc4", 1, 32'(lat), 32'd1);
    chkB("t5ErrAc4", 1, er, 1'b1);

    // Async reset between edges clears the held read data at once.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("t1Rdata0Async", 0, rdata0D[0], 32'd0);
    chk("t1Rdata1Async", 0, rdata1D[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Contention right after reset: port 0 takes the first tie.
    contend(0);
    contend(1);

    // Reset in the second cycle of a 4-cycle access.
    @(negedge clk);
    setReq(1, 0, 1, 0, 32'd7, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chkB("t6ReadFlagDrop", 1, rdF[1], 1'b0);
    chk("t6AddrDrop", 1, memAddrD[1], 32'd0);
    setReq(1, 0, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chkB("t6NoAck", 1, ack0D[1], 1'b0);
    doReq(1, 0, 0, 32'd7, '0, rd, er, lat);
    chk("t6ReqLatency", 1, 32'(lat), 32'd5);
    chk("t6ReqData", 1, rd, 32'hA5A5_0007);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
